intr_priority_encoder: RTL and testbench
========================================

Name: intr_priority_encoder

Overview:
- Request side of the 6-source interrupt controller.
- Latches up to six interrupt request lines and applies a per-line mask.
- Resolves fixed priority against the in-service register and raises int_req to the CPU.
- On CPU acknowledge, presents the 3-bit interrupt code (1..6) and updates the in-service register; that register feeds the downstream 3-to-6 decode and service logic.

Parameters:
- NUM_IRQ, 6, number of request lines; fixed at 6 because the code width is 3 bits.
- CODE_W, 3, width of irq_code.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- irq_in  input  6  raw request lines; irq_in[i] is interrupt code i+1.
- irq_mask  input  6  1 = line masked; same indexing as irq_in.
- int_ack  input  1  CPU acknowledge, single-cycle pulse.
- eoi  input  1  end-of-interrupt, single-cycle pulse.
- int_req  output  1  interrupt request to CPU.
- irq_code  output  3  code of the acknowledged interrupt; 0 = none.
- code_valid  output  1  1-cycle pulse when irq_code is updated.
- isr_out  output  6  in-service register; code n occupies isr_out[6-n].
- irr_out  output  6  request register; same indexing as irq_in.

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-high.
- Reset values: int_req=0, irq_code=0, code_valid=0, isr_out=0, irr_out=0, FSM=IDLE. Reset asserted mid-handshake aborts it immediately; no ack or eoi is recorded.
- IRR update each cycle:
  - Level mode sets IRR bit i when irq_in[i]=1.
  - A bit clears only when its interrupt is acknowledged.
  - Masking does not clear IRR; it only blocks eligibility.
- Priority: code 1 is highest, code 6 is lowest.
- Eligible set: IRR & ~mask, restricted to codes strictly higher priority than the highest-priority set ISR bit (fully nested mode).
- best = highest-priority eligible code, computed combinationally.
- FSM has three states:
  - IDLE: if best exists, move to PEND and latch pend_code=best. int_req=0.
  - PEND: int_req=1.
    - If a higher-priority code becomes eligible, update pend_code (no state change).
    - If no code is eligible any more (masked or ISR change), return to IDLE and drop int_req the following cycle.
    - On int_ack=1, move to ACK.
  - ACK (one cycle): irq_code=pend_code, code_valid=1, set ISR bit for pend_code, clear IRR bit pend_code-1, int_req=0, then go to IDLE.
- Latency: irq_in rising to int_req=1 takes 2 cycles (IRR register, then FSM). int_ack to code_valid takes 1 cycle.
- int_ack in IDLE or ACK is ignored.
- irq_code holds its value until the next ACK; it does not return to 0 after code_valid.
- EOI clears the highest-priority set ISR bit. EOI with ISR=0 has no effect.
- Simultaneous EOI and ACK in one cycle: EOI clear is computed on the pre-update ISR, then the ACK bit is set. Both take effect.
- Reassertion: an irq_in still high after its IRR bit is cleared by ACK re-sets IRR on the next cycle (level mode).

Optional Feature:
- Macro IRQ_EDGE_TRIGGER_EN.
- Defined:
  - irq_in passes through a 2-flop synchroniser plus a previous-value register.
  - An IRR bit sets only on a 0->1 transition of the synchronised line.
  - Latency from irq_in to int_req becomes 4 cycles.
  - A held-high line does not re-request after ACK.
- Undefined: level-sensitive, no synchroniser, as described in Behaviour.

Decomposition:
- Shared package intr_pkg:
  - NUM_IRQ and CODE_W.
  - FSM state encoding: IDLE=2'd0, PEND=2'd1, ACK=2'd2.
  - CODE_NONE=3'd0.
  - Function code_to_isr_idx (n -> 6-n).
- One sub-module, intr_prio_resolve: combinational. Takes IRR, mask and ISR; returns best code (0 = none). Reused by the EOI highest-ISR lookup with mask=0 and ISR=0 inputs.

Test Plan:
- Single request: irq_in=6'b000100, mask=0. Expect int_req=1 after 2 cycles. Pulse int_ack; next cycle irq_code=3, code_valid=1, isr_out=6'b001000, irr_out=0.
- Priority: irq_in=6'b100001 set together. Expect first ACK gives code 1 (isr_out[5]=1). int_req reasserts only after eoi. Second ACK gives code 6, isr_out=6'b000001.
- Nesting: code 4 in service, then irq_in[1]=1. Expect int_req; ACK gives code 2 and isr_out=6'b010100. Separately, with code 4 in service, irq_in[4]=1 (code 5) gives no int_req until eoi.
- Mask and withdraw: in PEND with code 3, set irq_mask[2]=1. Expect int_req=0 within 2 cycles; irr_out[2] stays 1. Unmasking re-raises int_req.
- Simultaneous eoi and int_ack: code 3 in service, code 1 pending. Expect isr_out goes from 6'b001000 to 6'b100000 in one cycle.
- Async reset asserted in PEND: expect all outputs 0 immediately, without waiting for a clock edge. With IRQ_EDGE_TRIGGER_EN, a held-high line is not re-latched after reset release until it toggles.

Source files
------------

// File: rtl/intr_pkg.sv
// Shared definitions for the 6-source interrupt request encoder.
// Holds sizing constants, FSM state encoding and the code-to-ISR index mapping.
// Purely declarative; no logic or latency of its own.
package intr_pkg;

  localparam int NUM_IRQ = 6;
  localparam int CODE_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [CODE_W-1:0] CODE_NONE = 3'd0;

  // Code n (1..6) lives at isr bit 6-n, so code 1 is the MSB.
  function automatic logic [CODE_W-1:0] code_to_isr_idx(input logic [CODE_W-1:0] code);
    return 3'(NUM_IRQ) - code;
  endfunction

endpackage

// File: rtl/intr_prio_resolve.sv
// Fixed-priority resolver: best eligible code from IRR/mask, nested under the ISR.
// Purely combinational, zero latency.
// No flow control; result valid whenever the inputs are stable.
module intr_prio_resolve
  import intr_pkg::*;
(
  input  logic [NUM_IRQ-1:0] irr,
  input  logic [NUM_IRQ-1:0] mask,
  input  logic [NUM_IRQ-1:0] isr,
  output logic [CODE_W-1:0]  best
);

  // Highest-priority in-service code; 7 means nothing in service so every code qualifies.
  logic [CODE_W-1:0] top;

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    top = 3'd7;
    for (int n = NUM_IRQ; n >= 1; n--) begin
      if (isr[NUM_IRQ-n]) top = CODE_W'(n);
    end
    best = CODE_NONE;
    for (int n = NUM_IRQ; n >= 1; n--) begin
      if (irr[n-1] && !mask[n-1] && (CODE_W'(n) < top)) best = CODE_W'(n);
    end
  end

endmodule

// File: rtl/intr_priority_encoder.sv
// Interrupt request side: latches requests, resolves nested priority, runs the CPU ack handshake.
// irq_in -> int_req 2 cycles (4 with IRQ_EDGE_TRIGGER_EN); int_ack -> code_valid 1 cycle.
// No backpressure; int_ack/eoi are single-cycle pulses, int_ack outside PEND is ignored.
module intr_priority_encoder
  import intr_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               int_ack,
  input  logic               eoi,
  output logic               int_req,
  output logic [CODE_W-1:0]  irq_code,
  output logic               code_valid,
  output logic [NUM_IRQ-1:0] isr_out,
  output logic [NUM_IRQ-1:0] irr_out
);

  state_t             state_q, state_d;
  logic [CODE_W-1:0]  pend_code_q, pend_code_d;
  logic [NUM_IRQ-1:0] irr_q, irr_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic               int_req_q, int_req_d;
  logic [CODE_W-1:0]  irq_code_q, irq_code_d;
  logic               code_valid_q, code_valid_d;

  logic [NUM_IRQ-1:0] irr_set;
  logic [NUM_IRQ-1:0] isr_rev;
  logic [CODE_W-1:0]  best_code;
  logic [CODE_W-1:0]  eoi_code;
  logic               ack_fire;
  logic [NUM_IRQ-1:0] ack_isr_set, ack_irr_clr, eoi_clr;

`ifdef IRQ_EDGE_TRIGGER_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q, prev_q;

  // Synchroniser and edge history reset to all ones so a line already high at reset release is not seen as a new edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign irr_set = sync2_q & ~prev_q;
`else
  assign irr_set = irq_in;
`endif

  // Bit-reverse ISR into request indexing so the resolver can find the highest in-service code.
  always_comb begin
    isr_rev = '0;
    for (int i = 0; i < NUM_IRQ; i++) isr_rev[i] = isr_q[NUM_IRQ-1-i];
  end

  intr_prio_resolve u_req_resolve (
    .irr  (irr_q),
    .mask (irq_mask),
    .isr  (isr_q),
    .best (best_code)
  );

  intr_prio_resolve u_eoi_resolve (
    .irr  (isr_rev),
    .mask ('0),
    .isr  ('0),
    .best (eoi_code)
  );

  // Handshake FSM next state; ack takes precedence over a same-cycle loss of eligibility.
  always_comb begin
    state_d      = state_q;
    pend_code_d  = pend_code_q;
    irq_code_d   = irq_code_q;
    code_valid_d = 1'b0;
    ack_fire     = 1'b0;
    case (state_q)
      IDLE: begin
        if (best_code != CODE_NONE) begin
          state_d     = PEND;
          pend_code_d = best_code;
        end
      end
      PEND: begin
        if (int_ack) begin
          state_d      = ACK;
          ack_fire     = 1'b1;
          irq_code_d   = pend_code_q;
          code_valid_d = 1'b1;
        end else if (best_code == CODE_NONE) begin
          state_d = IDLE;
        end else begin
          pend_code_d = best_code;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    int_req_d = (state_d == PEND);
  end

  // ISR/IRR updates: EOI works on the pre-ack ISR, and an ack clear beats a same-cycle re-set of IRR.
  always_comb begin
    ack_isr_set = '0;
    ack_irr_clr = '0;
    eoi_clr     = '0;
    if (ack_fire) begin
      ack_isr_set[code_to_isr_idx(pend_code_q)] = 1'b1;
      ack_irr_clr[pend_code_q - 3'd1]          = 1'b1;
    end
    if (eoi && (eoi_code != CODE_NONE)) begin
      eoi_clr[code_to_isr_idx(eoi_code)] = 1'b1;
    end
    isr_d = (isr_q & ~eoi_clr) | ack_isr_set;
    irr_d = (irr_q | irr_set) & ~ack_irr_clr;
  end

  // All state and registered outputs; reset aborts any handshake in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pend_code_q  <= CODE_NONE;
      irr_q        <= '0;
      isr_q        <= '0;
      int_req_q    <= 1'b0;
      irq_code_q   <= CODE_NONE;
      code_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_code_q  <= pend_code_d;
      irr_q        <= irr_d;
      isr_q        <= isr_d;
      int_req_q    <= int_req_d;
      irq_code_q   <= irq_code_d;
      code_valid_q <= code_valid_d;
    end
  end

  assign int_req    = int_req_q;
  assign irq_code   = irq_code_q;
  assign code_valid = code_valid_q;
  assign isr_out    = isr_q;
  assign irr_out    = irr_q;

endmodule

// File: tb/tb_intr_priority_encoder.sv
// Self-checking bench for intr_priority_encoder.
// Expected ack results are queued when int_ack is driven and compared when code_valid appears.
// Inputs change 1 ns after the rising edge; outputs are read there or on the falling edge.
module tb_intr_priority_encoder;

`ifdef IRQ_EDGE_TRIGGER_EN
  localparam int REQ_LAT = 4;
`else
  localparam int REQ_LAT = 2;
`endif

  logic       clk;
  logic       reset;
  logic [5:0] irq_in;
  logic [5:0] irq_mask;
  logic       int_ack;
  logic       eoi;
  logic       int_req;
  logic [2:0] irq_code;
  logic       code_valid;
  logic [5:0] isr_out;
  logic [5:0] irr_out;

  intr_priority_encoder dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .irq_mask   (irq_mask),
    .int_ack    (int_ack),
    .eoi        (eoi),
    .int_req    (int_req),
    .irq_code   (irq_code),
    .code_valid (code_valid),
    .isr_out    (isr_out),
    .irr_out    (irr_out)
  );

  typedef struct {
    logic [2:0] code;
    logic [5:0] isr;
    logic [5:0] irr;
  } exp_t;

  exp_t sb_q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cv_seen = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every code_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && code_valid === 1'b1) begin
      exp_t e;
      cv_seen++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected code_valid with code=%0d, none expected", irq_code);
      end else begin
        e = sb_q.pop_front();
        if (irq_code !== e.code) begin
          errors++;
          $display("FAIL sb_code got=%0d exp=%0d", irq_code, e.code);
        end
        checks++;
        if (isr_out !== e.isr) begin
          errors++;
          $display("FAIL sb_isr got=%b exp=%b", isr_out, e.isr);
        end
        checks++;
        if (irr_out !== e.irr) begin
          errors++;
          $display("FAIL sb_irr got=%b exp=%b", irr_out, e.irr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle request pulse; returns once IRR holds it (FSM not yet in PEND).
  task automatic raise(input logic [5:0] lines);
    irq_in = lines;
    tick();
    irq_in = 6'b0;
    repeat (REQ_LAT - 2) tick();
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  // Queue the expectation, pulse int_ack, and wait (bounded) for the scoreboard to consume it.
  task automatic ack_and_expect(input logic [2:0] code, input logic [5:0] isr, input logic [5:0] irr);
    exp_t e;
    int   seen0;
    e.code = code; e.isr = isr; e.irr = irr;
    sb_q.push_back(e);
    seen0   = cv_seen;
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    checks++;
    if (code_valid !== 1'b1 || int_req !== 1'b0) begin
      errors++;
      $display("FAIL ack_latency code=%0d code_valid=%b int_req=%b exp 1/0", code, code_valid, int_req);
    end
    for (int i = 0; i < 4 && cv_seen == seen0; i++) tick();
    checks++;
    if (cv_seen == seen0) begin
      errors++;
      $display("FAIL ack_timeout code=%0d no code_valid seen", code);
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; irq_in = '0; irq_mask = '0; int_ack = 1'b0; eoi = 1'b0;
    repeat (2) tick();
    checks++;
    if ({int_req, irq_code, code_valid, isr_out, irr_out} !== 17'b0) begin
      errors++;
      $display("FAIL reset_values got req=%b code=%0d cv=%b isr=%b irr=%b exp all 0",
               int_req, irq_code, code_valid, isr_out, irr_out);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (int_req !== 1'b0 || isr_out !== 6'b0) begin
      errors++;
      $display("FAIL reset_idle got req=%b isr=%b exp 0", int_req, isr_out);
    end
  endtask

  task automatic test_single();
    raise(6'b000100);
    checks++;
    if (irr_out !== 6'b000100 || int_req !== 1'b0) begin
      errors++;
      $display("FAIL single_irr got irr=%b req=%b exp 000100/0", irr_out, int_req);
    end
    tick();
    checks++;
    if (int_req !== 1'b1) begin
      errors++;
      $display("FAIL single_req got=%b exp=1", int_req);
    end
    ack_and_expect(3'd3, 6'b001000, 6'b000000);
    checks++;
    if (int_req !== 1'b0 || code_valid !== 1'b0 || irq_code !== 3'd3) begin
      errors++;
      $display("FAIL single_hold got req=%b cv=%b code=%0d exp 0/0/3", int_req, code_valid, irq_code);
    end
    pulse_eoi();
    checks++;
    if (isr_out !== 6'b0) begin
      errors++;
      $display("FAIL single_eoi got isr=%b exp=000000", isr_out);
    end
  endtask

  task automatic test_priority();
    raise(6'b100001);
    tick();
    ack_and_expect(3'd1, 6'b100000, 6'b100000);
    repeat (3) tick();
    checks++;
    if (int_req !== 1'b0 || irr_out !== 6'b100000) begin
      errors++;
      $display("FAIL prio_blocked got req=%b irr=%b exp 0/100000", int_req, irr_out);
    end
    pulse_eoi();
    tick();
    checks++;
    if (int_req !== 1'b1) begin
      errors++;
      $display("FAIL prio_rereq got=%b exp=1", int_req);
    end
    ack_and_expect(3'd6, 6'b000001, 6'b000000);
    pulse_eoi();
  endtask

  task automatic test_nesting();
    raise(6'b001000);
    tick();
    ack_and_expect(3'd4, 6'b000100, 6'b000000);
    raise(6'b000010);
    tick();
    checks++;
    if (int_req !== 1'b1) begin
      errors++;
      $display("FAIL nest_req got=%b exp=1", int_req);
    end
    ack_and_expect(3'd2, 6'b010100, 6'b000000);
    pulse_eoi();
    checks++;
    if (isr_out !== 6'b000100) begin
      errors++;
      $display("FAIL nest_eoi got isr=%b exp=000100", isr_out);
    end
    raise(6'b010000);
    repeat (3) tick();
    checks++;
    if (int_req !== 1'b0 || irr_out !== 6'b010000) begin
      errors++;
      $display("FAIL nest_lower got req=%b irr=%b exp 0/010000", int_req, irr_out);
    end
    pulse_eoi();
    tick();
    checks++;
    if (int_req !== 1'b1) begin
      errors++;
      $display("FAIL nest_after_eoi got=%b exp=1", int_req);
    end
    ack_and_expect(3'd5, 6'b000010, 6'b000000);
    pulse_eoi();
  endtask

  task automatic test_mask();
    raise(6'b000100);
    tick();
    irq_mask = 6'b000100;
    tick();
    checks++;
    if (int_req !== 1'b0) begin
      errors++;
      $display("FAIL mask_drop got req=%b exp=0", int_req);
    end
    tick();
    checks++;
    if (int_req !== 1'b0 || irr_out !== 6'b000100) begin
      errors++;
      $display("FAIL mask_hold got req=%b irr=%b exp 0/000100", int_req, irr_out);
    end
    irq_mask = 6'b0;
    tick();
    checks++;
    if (int_req !== 1'b1) begin
      errors++;
      $display("FAIL mask_unmask got=%b exp=1", int_req);
    end
    ack_and_expect(3'd3, 6'b001000, 6'b000000);
  endtask

  task automatic test_eoi_ack();
    exp_t e;
    raise(6'b000001);
    tick();
    checks++;
    if (int_req !== 1'b1 || isr_out !== 6'b001000) begin
      errors++;
      $display("FAIL eack_setup got req=%b isr=%b exp 1/001000", int_req, isr_out);
    end
    e.code = 3'd1; e.isr = 6'b100000; e.irr = 6'b000000;
    sb_q.push_back(e);
    int_ack = 1'b1;
    eoi     = 1'b1;
    tick();
    int_ack = 1'b0;
    eoi     = 1'b0;
    checks++;
    if (isr_out !== 6'b100000 || code_valid !== 1'b1) begin
      errors++;
      $display("FAIL eack_isr got isr=%b cv=%b exp 100000/1", isr_out, code_valid);
    end
    tick();
    pulse_eoi();
    checks++;
    if (isr_out !== 6'b0) begin
      errors++;
      $display("FAIL eack_clear got isr=%b exp=000000", isr_out);
    end
  endtask

  task automatic test_reassert();
    logic [5:0] exp_irr;
`ifdef IRQ_EDGE_TRIGGER_EN
    exp_irr = 6'b000000;
`else
    exp_irr = 6'b001000;
`endif
    irq_in = 6'b001000;
    repeat (REQ_LAT) tick();
    ack_and_expect(3'd4, 6'b000100, 6'b000000);
    checks++;
    if (irr_out !== exp_irr) begin
      errors++;
      $display("FAIL reassert_irr got=%b exp=%b", irr_out, exp_irr);
    end
    irq_in = 6'b0;
  endtask

  task automatic test_async_reset();
    logic [5:0] exp_irr;
`ifdef IRQ_EDGE_TRIGGER_EN
    exp_irr = 6'b000000;
`else
    exp_irr = 6'b000010;
`endif
    irq_in = 6'b000010;
    repeat (REQ_LAT) tick();
    checks++;
    if (int_req !== 1'b1) begin
      errors++;
      $display("FAIL areset_setup got req=%b exp=1", int_req);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({int_req, irq_code, code_valid, isr_out, irr_out} !== 17'b0) begin
      errors++;
      $display("FAIL areset_async got req=%b code=%0d cv=%b isr=%b irr=%b exp all 0",
               int_req, irq_code, code_valid, isr_out, irr_out);
    end
    tick();
    reset = 1'b0;
    repeat (REQ_LAT) tick();
    checks++;
    if (irr_out !== exp_irr) begin
      errors++;
      $display("FAIL areset_relatch got irr=%b exp=%b", irr_out, exp_irr);
    end
    irq_in = 6'b0;
    reset  = 1'b1;
    tick();
    reset  = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_nesting();
    test_mask();
    test_eoi_ack();
    test_reassert();
    test_async_reset();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover %0d expectations never matched, exp 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
